// File: rtl/crd_stream_pkg.sv
// crd_stream_pkg: shared token layout, token types and FSM states for the coordinate stream blocks.
package crd_stream_pkg;
  localparam int EOS_BIT = 16;
  localparam int TYPE_HI = 9;
  localparam int TYPE_LO = 8;
  localparam logic [1:0] TOK_STOP = 2'h0;
  localparam logic [1:0] TOK_DONE = 2'h1;
  typedef enum logic [2:0] {
    ST_START = 3'd0,
    ST_IDLE  = 3'd1,
    ST_EMIT  = 3'd2,
    ST_STOP  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;
  function automatic logic [16:0] eos_tok(input logic [1:0] typ, input logic [7:0] lvl);
    logic [16:0] t;
    t = '0;
    t[EOS_BIT] = 1'b1;
    t[TYPE_HI:TYPE_LO] = typ;
    t[7:0] = lvl;
    return t;
  endfunction
endpackage

// File: rtl/crd_token_fifo.sv
// crd_token_fifo: registered-array token buffer; push is judged against full at the start of the cycle.
module crd_token_fifo #(
  parameter int DEPTH = 8,
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clk_en,
  input  logic         i_push,
  input  logic [W-1:0] i_wdata,
  input  logic         i_pop,
  output logic [W-1:0] o_rdata,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0] r_cnt;
  logic w_push, w_pop;
  assign o_full = r_cnt == (AW+1)'(DEPTH);
  assign o_empty = r_cnt == '0;
  assign w_push = i_push & ~o_full;
  assign w_pop = i_pop & ~o_empty;
  assign o_rdata = r_mem[r_rd];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr <= '0;
      r_rd <= '0;
      r_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_clk_en) begin
      if (w_push) begin
        r_mem[r_wr] <= i_wdata;
        r_wr <= r_wr + 1'b1;
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
endmodule

// File: rtl/crd_stream_src.sv
// crd_stream_src: turns segment descriptors into coordinate, stop and done tokens on a buffered stream.
module crd_stream_src
  import crd_stream_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clk_en,
  input  logic        tile_en,
  input  logic [15:0] seg_start,
  input  logic [15:0] seg_len,
  input  logic [7:0]  seg_stop_lvl,
  input  logic        seg_last,
  input  logic        seg_valid,
  output logic        seg_ready,
  output logic [16:0] coord_out,
  output logic        coord_out_valid,
  input  logic        coord_out_ready,
  output logic        busy
);
  state_t r_state;
  logic [15:0] r_cur, r_cnt, r_len;
  logic [7:0] r_lvl;
  logic r_last;
  logic w_want, w_push, w_full, w_empty;
  logic [16:0] w_tok;
  assign w_want = (r_state == ST_EMIT) | (r_state == ST_STOP) | (r_state == ST_DONE);
  // tile_en stands in for the buffer clock gate, so the FSM must not advance on a push the buffer won't see
  assign w_push = w_want & ~w_full & tile_en;
  assign w_tok = (r_state == ST_EMIT) ? {1'b0, r_cur} :
                 (r_state == ST_STOP) ? eos_tok(TOK_STOP, r_lvl) : eos_tok(TOK_DONE, 8'h00);
  assign seg_ready = r_state == ST_IDLE;
  assign coord_out_valid = ~w_empty;
  assign busy = w_want | ~w_empty;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_START;
      r_cur <= '0;
      r_cnt <= '0;
      r_len <= '0;
      r_lvl <= '0;
      r_last <= 1'b0;
    end else if (clk_en) begin
      case (r_state)
        ST_START: if (tile_en) r_state <= ST_IDLE;
        ST_IDLE: if (seg_valid) begin
          r_cur <= seg_start;
          r_len <= seg_len;
          r_lvl <= seg_stop_lvl;
          r_last <= seg_last;
          r_cnt <= '0;
          r_state <= (seg_len != 16'h0) ? ST_EMIT : ST_STOP;
        end
        ST_EMIT: if (w_push) begin
          r_cur <= r_cur + 16'h1;
          r_cnt <= r_cnt + 16'h1;
          if (r_cnt == r_len - 16'h1) r_state <= ST_STOP;
        end
        ST_STOP: if (w_push) r_state <= r_last ? ST_DONE : ST_IDLE;
        ST_DONE: if (w_push) r_state <= ST_IDLE;
        default: r_state <= ST_START;
      endcase
    end
  end
  crd_token_fifo #(.DEPTH(FIFO_DEPTH), .W(17)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .i_clk_en(clk_en & tile_en),
    .i_push(w_push),
    .i_wdata(w_tok),
    .i_pop(coord_out_ready),
    .o_rdata(coord_out),
    .o_full(w_full),
    .o_empty(w_empty)
  );
endmodule

// File: tb/tb_crd_stream_src.sv
// tb_crd_stream_src: random and directed descriptors checked against a token-queue model of the stream.
module tb_crd_stream_src;
  logic clk = 1'b0, rst_n = 1'b0, clk_en = 1'b1, tile_en = 1'b0;
  logic [15:0] seg_start = '0, seg_len = '0;
  logic [7:0] seg_stop_lvl = '0;
  logic seg_last = 1'b0, seg_valid = 1'b0, seg_ready;
  logic [16:0] coord_out;
  logic coord_out_valid, coord_out_ready = 1'b1, busy;
  logic [16:0] q_exp [$];
  int total = 0, bad = 0, pops = 0, cyc = 0;
  logic rnd = 1'b0;
  logic [16:0] seq [8];
  logic [16:0] held;

  crd_stream_src #(.FIFO_DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .tile_en(tile_en),
    .seg_start(seg_start), .seg_len(seg_len), .seg_stop_lvl(seg_stop_lvl),
    .seg_last(seg_last), .seg_valid(seg_valid), .seg_ready(seg_ready),
    .coord_out(coord_out), .coord_out_valid(coord_out_valid),
    .coord_out_ready(coord_out_ready), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  // model: a descriptor expands into its token list; every pop must match the queue head
  always @(negedge clk) begin
    logic [16:0] t;
    if (!rst_n) q_exp.delete();
    else begin
      if (clk_en && tile_en && coord_out_valid && coord_out_ready) begin
        pops++;
        total++;
        if (q_exp.size() == 0) begin
          bad++;
          $display("FAIL stream: unexpected token %h", coord_out);
        end else begin
          t = q_exp.pop_front();
          if (coord_out !== t) begin
            bad++;
            $display("FAIL stream: got %h want %h", coord_out, t);
          end
        end
      end
      if (clk_en && seg_valid && seg_ready) begin
        for (int i = 0; i < int'(seg_len); i++) q_exp.push_back({1'b0, seg_start + 16'(i)});
        q_exp.push_back({1'b1, 8'h00, seg_stop_lvl});
        if (seg_last) q_exp.push_back({1'b1, 16'h0100});
      end
    end
  end

  always @(posedge clk) if (rnd) begin
    #1;
    coord_out_ready = $urandom_range(0, 3) != 0;
    clk_en = $urandom_range(0, 9) != 0;
  end

  task automatic send(input logic [15:0] s, input logic [15:0] l, input logic [7:0] lv, input logic la);
    bit ok = 0;
    @(posedge clk); #1;
    seg_start = s; seg_len = l; seg_stop_lvl = lv; seg_last = la; seg_valid = 1'b1;
    for (int i = 0; i < 1000 && !ok; i++) begin
      @(negedge clk);
      if (seg_ready && clk_en) ok = 1;
    end
    @(posedge clk); #1;
    seg_valid = 1'b0;
    if (!ok) begin
      total++; bad++;
      $display("FAIL send_timeout: got no handshake want handshake for start %h", s);
    end
  endtask

  task automatic expect_seq(input string nm, input int n);
    @(negedge clk);
    chk({nm, "_latency"}, {31'b0, coord_out_valid}, 32'd0);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk({nm, "_valid"}, {31'b0, coord_out_valid}, 32'd1);
      chk({nm, "_tok"}, {15'b0, coord_out}, {15'b0, seq[i]});
    end
  endtask

  task automatic drain(input string nm, input int budget);
    bit ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (q_exp.size() == 0 && !coord_out_valid && !busy) ok = 1;
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s_drain: got %0d tokens pending want 0", nm, q_exp.size());
    end
  endtask

  initial begin
    #1;
    chk("rst_valid", {31'b0, coord_out_valid}, 0);
    chk("rst_data", {15'b0, coord_out}, 0);
    chk("rst_ready", {31'b0, seg_ready}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("start_hold", {31'b0, seg_ready}, 0);
    @(posedge clk); #1 tile_en = 1'b1;
    @(negedge clk);
    chk("start_wait", {31'b0, seg_ready}, 0);
    @(negedge clk);
    chk("idle_ready", {31'b0, seg_ready}, 1);

    send(16'd5, 16'd3, 8'd0, 1'b1);
    seq = '{17'h00005, 17'h00006, 17'h00007, 17'h10000, 17'h10100, 17'h0, 17'h0, 17'h0};
    expect_seq("basic", 5);
    drain("basic", 50);

    send(16'd9, 16'd0, 8'd1, 1'b0);
    @(negedge clk);
    chk("empty_ready_lo", {31'b0, seg_ready}, 0);
    @(negedge clk);
    chk("empty_ready_hi", {31'b0, seg_ready}, 1);
    chk("empty_valid", {31'b0, coord_out_valid}, 1);
    chk("empty_tok", {15'b0, coord_out}, 32'h10001);
    drain("empty", 50);

    coord_out_ready = 1'b0;
    send(16'd100, 16'd12, 8'd2, 1'b0);
    repeat (20) @(negedge clk);
    chk("bp_valid", {31'b0, coord_out_valid}, 1);
    chk("bp_busy", {31'b0, busy}, 1);
    chk("bp_stalled", {31'b0, seg_ready}, 0);
    chk("bp_head", {15'b0, coord_out}, 32'd100);
    @(posedge clk); #1;
    pops = 0;
    coord_out_ready = 1'b1;
    drain("bp", 100);
    chk("bp_count", pops, 13);

    send(16'hFFFE, 16'd3, 8'd3, 1'b0);
    seq = '{17'h0FFFE, 17'h0FFFF, 17'h00000, 17'h10003, 17'h0, 17'h0, 17'h0, 17'h0};
    expect_seq("wrap", 4);
    drain("wrap", 50);

    send(16'd200, 16'd5, 8'd0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", {31'b0, coord_out_valid}, 0);
    chk("midrst_busy", {31'b0, busy}, 0);
    chk("midrst_data", {15'b0, coord_out}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    send(16'd300, 16'd2, 8'd5, 1'b1);
    seq = '{17'h0012C, 17'h0012D, 17'h10005, 17'h10100, 17'h0, 17'h0, 17'h0, 17'h0};
    expect_seq("after_rst", 4);
    drain("after_rst", 50);

    send(16'd400, 16'd6, 8'd7, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    clk_en = 1'b0;
    held = coord_out;
    chk("freeze_head", {15'b0, held}, 32'd401);
    repeat (4) begin
      @(negedge clk);
      chk("freeze_data", {15'b0, coord_out}, {15'b0, held});
      chk("freeze_valid", {31'b0, coord_out_valid}, 1);
      chk("freeze_state", {31'b0, seg_ready}, 0);
    end
    @(posedge clk); #1 clk_en = 1'b1;
    drain("freeze", 50);

    rnd = 1'b1;
    for (int k = 0; k < 40; k++)
      send(16'($urandom), 16'($urandom_range(0, 20)), 8'($urandom), 1'($urandom_range(0, 1)));
    rnd = 1'b0;
    @(posedge clk); #2;
    coord_out_ready = 1'b1;
    clk_en = 1'b1;
    drain("random", 3000);
    chk("model_empty", q_exp.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/crd_stream_src.md
# crd_stream_src

Coordinate stream source for the sparse pipeline: the transmitter end of the 17-bit packed coordinate protocol that crddrop-style blocks consume. It accepts fiber segment descriptors over a ready/valid port and emits, per segment, the coordinates `start .. start+len-1`, then one stop token. After the segment flagged `last`, it emits a done token. Output goes through an 8-entry buffer, so downstream backpressure never loses data.

## Interface
- `FIFO_DEPTH`, 8: output buffer entries, power of two.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `clk_en`  in  1  global enable; when low, all state freezes.
- `tile_en`  in  1  tile enable; gates the buffer clock (`clk & tile_en`) and releases the FSM from START.
- `seg_start`  in  16  first coordinate of the segment.
- `seg_len`  in  16  coordinate count; 0 means an empty fiber.
- `seg_stop_lvl`  in  8  stop level written into this segment's stop token.
- `seg_last`  in  1  last segment of the tensor; a done token follows it.
- `seg_valid`  in  1  descriptor valid.
- `seg_ready`  out  1  descriptor accepted when `seg_valid & seg_ready` is sampled at a rising edge.
- `coord_out`  out  17  packed token. Bit 16 is eos. When eos=0, bits [15:0] are the coordinate. When eos=1, bits [9:8] are the token type (0 = stop, 1 = done), bits [7:0] are the stop level, and all other bits are 0.
- `coord_out_valid`  out  1  buffer non-empty.
- `coord_out_ready`  in  1  downstream pop.
- `busy`  out  1  FSM is in EMIT, STOP or DONE, or the buffer is non-empty.

## Operation
- FSM states: START, IDLE, EMIT, STOP, DONE.
- Reset values:
  - FSM state = START.
  - Buffer empty.
  - `coord_out_valid` = 0, `coord_out` = 0, `seg_ready` = 0, `busy` = 0.
  - Internal registers `cnt`, `cur`, `len_q`, `lvl_q`, `last_q` = 0.
- START: no pushes. Advances to IDLE when `tile_en` = 1.
- IDLE: `seg_ready` = 1. On handshake:
  - latch `cur` = `seg_start`, `len_q` = `seg_len`, `lvl_q` = `seg_stop_lvl`, `last_q` = `seg_last`, and `cnt` = 0;
  - go to EMIT if `seg_len` != 0, otherwise to STOP.
- EMIT: push `{1'b0, cur}` whenever the buffer is not full.
  - Each push: `cur` += 1 (16-bit wrap, 16'hFFFF -> 16'h0000) and `cnt` += 1.
  - The push with `cnt == len_q - 1` moves the FSM to STOP.
- STOP: push `{1'b1, 6'h0, 2'b00, lvl_q}` when the buffer is not full. Then go to DONE if `last_q`, else IDLE.
- DONE: push `{1'b1, 16'h0100}` when the buffer is not full, then go to IDLE (ready for the next tensor).
- Buffer full: no push and no state change. The held token is re-presented every cycle until it is pushed.
- Push and pop in the same cycle at full: the pop frees a slot only for the next cycle. The push is evaluated against `full` at the start of the cycle.
- Push and pop in the same cycle when empty: the push lands and valid rises next cycle; there is no bypass.
- `clk_en` = 0: FSM, counters and buffer all hold. `seg_ready` still reflects the state.
- Reset asserted mid-segment: all state is discarded immediately. No further tokens are emitted for that segment.
- `seg_len` = 16'hFFFF is legal: 65535 coordinates, and `cnt` does not overflow.

## Timing
- Descriptor accepted at edge N → first push in cycle N+1 → `coord_out_valid` high in cycle N+2.
- Throughput is one token per cycle when the buffer is not full.
- A segment of length L occupies L+1 push cycles (L+2 when `last`), plus one IDLE cycle before the next descriptor.
- Buffer output is registered-array read (`reg_array[rd_ptr]`). Pop takes effect at the edge where `coord_out_ready & coord_out_valid`.
- Write pointer wraps from 7 to 0. Full is `count == FIFO_DEPTH`; empty is `count == 0`.

## Structure
- Shared package `crd_stream_pkg` holds:
  - bit positions `EOS_BIT` = 16 and `TYPE_HI`/`TYPE_LO` = 9/8;
  - `TOK_STOP` = 2'h0 and `TOK_DONE` = 2'h1;
  - the FSM state enum.
- One sub-module: `crd_token_fifo` (depth `FIFO_DEPTH`, width 17, `clk_en`, async reset). The same buffer is reusable by the stream consumers.
- Top level contains the FSM, the `cur`/`cnt` registers and the token mux.

## Test plan
- Reset, then `tile_en`=1, then descriptor (start=5, len=3, lvl=0, last=1) with `coord_out_ready` held at 1 → output 0x00005, 0x00006, 0x00007, 0x10000, 0x10100 on consecutive cycles; first valid two cycles after the handshake.
- Empty fiber (start=9, len=0, lvl=1, last=0) → single token 0x10001; `seg_ready` high again two cycles after the handshake.
- Backpressure: len=12 with `coord_out_ready`=0 → exactly 8 tokens buffered and `busy`=1. Release → remaining 4 coordinates plus the stop token arrive in order, no loss or duplication.
- Wrap: start=16'hFFFE, len=3 → 0x0FFFE, 0x0FFFF, 0x00000, then the stop token.
- Reset pulsed mid-EMIT after 2 of 5 coordinates → `coord_out_valid`=0 immediately; after re-enable, a new descriptor streams cleanly.
- `clk_en` low for 4 cycles mid-segment → output and internal state frozen; the stream resumes unchanged when `clk_en` returns to 1.
